// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI responder.
package spi_pkg;
    localparam int SPI_BYTE_W          = 8;
    localparam int SPI_BUFSIZE_DEFAULT = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_DONE    = 2'd2,
        S_WAIT_SS = 2'd3
    } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with registered one-cycle rise/fall pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign level = s2;
endmodule

// File: rtl/spi_responder.sv
// SPI responder: oversampled mode-0, LSB-first, fixed BUFSIZE-byte frames.
module spi_responder
    import spi_pkg::*;
#(
    parameter int BUFSIZE = SPI_BUFSIZE_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sclk,
    input  logic                               mosi,
    input  logic                               ss,
    output logic                               miso,
    input  logic [BUFSIZE-1:0][SPI_BYTE_W-1:0] tx_data,
    output logic [BUFSIZE-1:0][SPI_BYTE_W-1:0] rx_data,
    output logic                               rx_valid,
    output logic                               rx_err,
    output logic                               busy
);
    localparam int         W       = BUFSIZE * SPI_BYTE_W;
    localparam logic [3:0] BYTES   = 4'(BUFSIZE);
    localparam logic [1:0] IDLE    = S_IDLE;
    localparam logic [1:0] ACTIVE  = S_ACTIVE;
    localparam logic [1:0] DONE    = S_DONE;
    localparam logic [1:0] WAIT_SS = S_WAIT_SS;

    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge u_ss   (.clk(clk), .rst(rst), .d(ss),   .level(ss_lvl),
                          .rise(ss_rise), .fall(ss_fall));
    spi_sync_edge u_sclk (.clk(clk), .rst(rst), .d(sclk), .level(sclk_lvl_unused),
                          .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge u_mosi (.clk(clk), .rst(rst), .d(mosi), .level(mosi_lvl),
                          .rise(unused_mosi_rise), .fall(unused_mosi_fall));

    logic [1:0]   state;
    logic [1:0]   settle;
    logic [W-1:0] tx_sr;
    logic [W-1:0] rx_sr;
    logic [W-1:0] rx_q;
    logic [2:0]   bit_pos;
    logic [3:0]   byte_pos;
    logic         overrun;

    // Until the synchronizers have filled after reset, a high ss means the
    // master was mid-frame; park in WAIT_SS instead of treating it as a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            settle   <= 2'd0;
            miso     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_q     <= '0;
            bit_pos  <= 3'd0;
            byte_pos <= 4'd0;
            overrun  <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (settle != 2'd3) settle <= settle + 2'd1;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (settle != 2'd3) begin
                        if (ss_lvl) state <= WAIT_SS;
                    end else if (ss_rise) begin
                        tx_sr    <= tx_data >> 1;
                        miso     <= tx_data[0][0];
                        bit_pos  <= 3'd0;
                        byte_pos <= 4'd0;
                        overrun  <= 1'b0;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (ss_fall) begin
                        miso <= 1'b0;
                        if (byte_pos == BYTES && bit_pos == 3'd0 && !overrun) begin
                            rx_q  <= rx_sr;
                            state <= DONE;
                        end else begin
                            rx_err <= 1'b1;
                            state  <= IDLE;
                        end
                    end else if (sclk_rise) begin
                        if (byte_pos < BYTES) begin
                            rx_sr   <= {mosi_lvl, rx_sr[W-1:1]};
                            bit_pos <= bit_pos + 3'd1;
                            if (bit_pos == 3'd7) byte_pos <= byte_pos + 4'd1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        // zeros shift in behind the data, so miso idles low past the end
                        miso  <= tx_sr[0];
                        tx_sr <= tx_sr >> 1;
                    end
                end
                DONE: begin
                    rx_valid <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    miso <= 1'b0;
                    if (!ss_lvl) state <= IDLE;
                end
            endcase
        end
    end

    assign rx_data = rx_q;
    assign busy    = (state == ACTIVE) || (state == DONE);
endmodule

// File: tb/tb_spi_responder.sv
// Directed + randomized frames against a frame-level model of the responder.
module tb_spi_responder;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sclk = 1'b0;
    logic            mosi = 1'b0;
    logic            ss = 1'b0;
    logic            miso;
    logic [2:0][7:0] tx_data = '0;
    logic [2:0][7:0] rx_data;
    logic            rx_valid, rx_err, busy;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [23:0] got_q[$];
    logic [23:0] exp_rx = '0;

    spi_responder #(.BUFSIZE(3)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_err(rx_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            got_q.push_back(rx_data);
        end
        if (rx_err) n_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One master frame: mode 0, 5-clk sclk phases, LSB-first.
    task automatic run(input string tag, input int nbits, input logic [31:0] mb,
                       input logic [23:0] tx, input int gap, input int chg_at,
                       input logic [23:0] chg_val, input int rst_at);
        logic [31:0] rb, exp_rb;
        int v0, e0;
        bit ok;
        rb = '0;
        exp_rb = '0;
        v0 = n_valid;
        e0 = n_err;
        ok = (rst_at < 0) && (nbits == 24);
        for (int i = 0; i < nbits; i++)
            if (i < 24 && !(rst_at >= 0 && i >= rst_at)) exp_rb[i] = tx[i];
        tx_data = tx;
        ss = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) tx_data = chg_val;
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                chk({tag, ":rst_miso"}, 32'(miso), 0);
                chk({tag, ":rst_rx_data"}, 32'(rx_data), 0);
                chk({tag, ":rst_busy"}, 32'(busy), 0);
                chk({tag, ":rst_pulses"}, 32'({rx_valid, rx_err}), 0);
                rst = 1'b0;
                exp_rx = '0;
                repeat (3) @(negedge clk);
                chk({tag, ":post_rst_busy"}, 32'(busy), 0);
            end
            mosi = mb[i];
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            rb[i] = miso;
            if (i == 1 && rst_at < 0) chk({tag, ":busy_mid"}, 32'(busy), 1);
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        ss = 1'b0;
        mosi = 1'b0;
        repeat (gap) @(negedge clk);
        chk({tag, ":miso_bits"}, rb, exp_rb);
        if (ok) exp_rx = mb[23:0];
        if (gap >= 8) begin
            chk({tag, ":valid_cnt"}, 32'(n_valid - v0), 32'(ok));
            chk({tag, ":err_cnt"}, 32'(n_err - e0), 32'(!ok && rst_at < 0));
            chk({tag, ":rx_data"}, 32'(rx_data), 32'(exp_rx));
            chk({tag, ":busy_end"}, 32'(busy), 0);
            if (ok && got_q.size() > 0) chk({tag, ":valid_data"}, 32'(got_q[$]), 32'(exp_rx));
        end
    endtask

    initial begin
        int v0;
        int kind, nb;
        logic [23:0] rtx;
        logic [31:0] rmb;

        repeat (3) @(negedge clk);
        chk("reset_miso", 32'(miso), 0);
        chk("reset_rx_data", 32'(rx_data), 0);
        chk("reset_pulses", 32'({rx_valid, rx_err}), 0);
        chk("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        run("normal", 24, 32'h000F3CA5, 24'h332211, 10, -1, '0, -1);
        run("short13", 13, 32'h00001234, 24'h445566, 10, -1, '0, -1);
        run("overrun26", 26, 32'h03ABCDEF, 24'h778899, 10, -1, '0, -1);
        run("reset_mid", 24, 32'h00C0FFEE, 24'h5A5A5A, 10, -1, '0, 10);
        run("after_rst", 24, 32'h00030201, 24'h123456, 10, -1, '0, -1);
        run("tx_change", 24, 32'h00AA55AA, 24'hFFFFFF, 10, 5, 24'h000000, -1);
        run("tx_next", 24, 32'h00135790, 24'h000000, 10, -1, '0, -1);

        v0 = n_valid;
        run("b2b_a", 24, 32'h00DEAD01, 24'h0A0B0C, 4, -1, '0, -1);
        run("b2b_b", 24, 32'h00BEEF02, 24'h0D0E0F, 4, -1, '0, -1);
        repeat (10) @(negedge clk);
        chk("b2b_valid_cnt", 32'(n_valid - v0), 2);
        if (got_q.size() >= 2) begin
            chk("b2b_first", 32'(got_q[got_q.size()-2]), 32'h00DEAD01);
            chk("b2b_second", 32'(got_q[got_q.size()-1]), 32'h00BEEF02);
        end else begin
            chk("b2b_queue_depth", 32'(got_q.size()), 2);
        end
        chk("b2b_rx_data", 32'(rx_data), 32'h00BEEF02);

        for (int k = 0; k < 6; k++) begin
            kind = int'($urandom_range(0, 2));
            nb = (kind == 0) ? 24 :
                 (kind == 1) ? int'($urandom_range(1, 23)) : int'($urandom_range(25, 30));
            rtx = 24'($urandom);
            rmb = $urandom;
            run("random", nb, rmb, rtx, 10, -1, '0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
